// File: rtl/bcd_cnt_pkg.sv
// Shared types and constants for the BCD digit counter.
// HEX_MODE_EN widens the digit range to 0..15 and disables load clamping.
package bcd_cnt_pkg;

    localparam int unsigned DIGIT_W = 4;

`ifdef HEX_MODE_EN
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd15;
`else
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
`endif

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10
    } state_e;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] val);
`ifdef HEX_MODE_EN
        return val;
`else
        return (val > DIGIT_MAX) ? DIGIT_MAX : val;
`endif
    endfunction

endpackage

// File: rtl/bcd_digit_counter_if.sv
// Control/status bundle between a digit counter and its controller.
// Output digit bit 3 feeds decoder input x0 (MSB), bit 0 feeds x3 (LSB).
interface bcd_digit_counter_if;
    import bcd_cnt_pkg::*;

    logic               run;
    logic               up_dn;
    logic               load;
    logic [DIGIT_W-1:0] load_val;
    logic [DIGIT_W-1:0] digit;
    logic               tc;
    logic               busy;

    modport master (
        output run, up_dn, load, load_val,
        input  digit, tc, busy
    );

    modport slave (
        input  run, up_dn, load, load_val,
        output digit, tc, busy
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles by PRESCALE, emitting a one-cycle step on the last count.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PS_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam logic [PS_W-1:0] LastCnt = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_q, cnt_d;
    logic            hit;

    assign hit  = (cnt_q == LastCnt);
    assign step = en & hit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = hit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_digit_counter.sv
// Single-digit up/down counter with prescaled stepping, parallel load and wrap pulse.
// Build with HEX_MODE_EN defined for a 0..15 range.
module bcd_digit_counter
    import bcd_cnt_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PS_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    bcd_digit_counter_if.slave       bus
);

    state_e             state_q, state_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               tc_q, tc_d;
    logic               busy;
    logic               ps_en;
    logic               ps_clr;
    logic               step;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a load overrides the normal transition in every state
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = bus.run ? StRun : StHold;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.run)  state_d = StRun;
                StRun:   if (!bus.run) state_d = StHold;
                StHold:  if (bus.run)  state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy   = (state_q == StRun);
        ps_en  = busy;
        ps_clr = bus.load | (busy & (state_d != StRun));
    end

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ps_en),
        .clr   (ps_clr),
        .step  (step)
    );

    // Load beats a coincident step, so tc cannot fire on a load cycle
    always_comb begin
        digit_d = digit_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            digit_d = clamp_digit(bus.load_val);
        end else if (step) begin
            if (bus.up_dn) begin
                if (digit_q == DIGIT_MAX) begin
                    digit_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    digit_d = digit_q + 1'b1;
                end
            end else begin
                if (digit_q == '0) begin
                    digit_d = DIGIT_MAX;
                    tc_d    = 1'b1;
                end else begin
                    digit_d = digit_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            digit_q <= digit_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.digit = digit_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Self-checking bench: vector table, directed corner sequences, then random stimulus
// against a cycle-level arithmetic model of the counter.
module tb_bcd_digit_counter;

    localparam int unsigned PRESCALE = 4;
`ifdef HEX_MODE_EN
    localparam int MAXV = 15;
`else
    localparam int MAXV = 9;
`endif
    localparam logic [3:0] LOAD12 = (12 > MAXV) ? 4'(MAXV) : 4'd12;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: only "running" matters; idle and hold behave identically
    int m_digit = 0;
    int m_tc    = 0;
    int m_ps    = 0;
    bit m_run   = 1'b0;

    bcd_digit_counter_if bus ();

    bcd_digit_counter #(
        .PRESCALE (PRESCALE),
        .PS_W     (16)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         run;
        bit         up;
        bit         ld;
        logic [3:0] lv;
        logic [3:0] e_digit;
        bit         e_tc;
        bit         e_busy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_digit = 0;
            m_tc    = 0;
            m_ps    = 0;
            m_run   = 1'b0;
        end else begin
            bit stp;
            stp  = m_run && (m_ps == int'(PRESCALE) - 1);
            m_tc = 0;
            if (bus.load) begin
                m_digit = (int'(bus.load_val) > MAXV) ? MAXV : int'(bus.load_val);
            end else if (stp) begin
                if (bus.up_dn) begin
                    m_digit = (m_digit + 1) % (MAXV + 1);
                    m_tc    = (m_digit == 0) ? 1 : 0;
                end else begin
                    m_digit = (m_digit + MAXV) % (MAXV + 1);
                    m_tc    = (m_digit == MAXV) ? 1 : 0;
                end
            end
            if (bus.load || (m_run && !bus.run)) m_ps = 0;
            else if (m_run) m_ps = (m_ps + 1) % int'(PRESCALE);
            m_run = bus.run;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit r, input bit rn, input bit u, input bit l,
                         input logic [3:0] v);
        rst          = r;
        bus.run      = rn;
        bus.up_dn    = u;
        bus.load     = l;
        bus.load_val = v;
        tick();
    endtask

    task automatic chk_out(input string name, input int d, input int t, input int b);
        chk({name, "_digit"}, 8'(bus.digit), 8'(d));
        chk({name, "_tc"},    8'(bus.tc),    8'(t));
        chk({name, "_busy"},  8'(bus.busy),  8'(b));
    endtask

    initial begin
        rst          = 1'b1;
        bus.run      = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;

        //          rst run up ld  lv      digit          tc  busy
        vecs[0]  = '{1, 0, 1, 0, 4'd0,  4'd0,          0, 0};
        vecs[1]  = '{0, 1, 1, 0, 4'd0,  4'd0,          0, 1};
        vecs[2]  = '{0, 1, 1, 0, 4'd0,  4'd0,          0, 1};
        vecs[3]  = '{0, 1, 1, 0, 4'd0,  4'd0,          0, 1};
        vecs[4]  = '{0, 1, 1, 0, 4'd0,  4'd0,          0, 1};
        vecs[5]  = '{0, 1, 1, 0, 4'd0,  4'd1,          0, 1};
        vecs[6]  = '{0, 0, 1, 0, 4'd0,  4'd1,          0, 0};
        vecs[7]  = '{0, 0, 1, 1, 4'd7,  4'd7,          0, 0};
        vecs[8]  = '{0, 0, 1, 1, 4'd12, LOAD12,        0, 0};
        vecs[9]  = '{0, 1, 0, 0, 4'd0,  LOAD12,        0, 1};
        vecs[10] = '{0, 1, 0, 0, 4'd0,  LOAD12,        0, 1};
        vecs[11] = '{0, 1, 0, 0, 4'd0,  LOAD12,        0, 1};
        vecs[12] = '{0, 1, 0, 0, 4'd0,  LOAD12,        0, 1};
        vecs[13] = '{0, 1, 0, 0, 4'd0,  LOAD12 - 4'd1, 0, 1};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].up, vecs[i].ld, vecs[i].lv);
            chk_out($sformatf("vec%0d", i), vecs[i].e_digit, vecs[i].e_tc, vecs[i].e_busy);
        end

        // Down-count from 0 wraps to max with tc, next step has no tc
        drive(1, 0, 0, 0, 4'd0);
        drive(0, 1, 0, 0, 4'd0);
        repeat (4) drive(0, 1, 0, 0, 4'd0);
        chk_out("dn_wrap", MAXV, 1, 1);
        drive(0, 1, 0, 0, 4'd0);
        chk_out("dn_wrap_tc_end", MAXV, 0, 1);
        repeat (3) drive(0, 1, 0, 0, 4'd0);
        chk_out("dn_next", MAXV - 1, 0, 1);

        // Up-count full lap: wrap lands 4*(MAXV+1) edges after entering run
        drive(1, 0, 1, 0, 4'd0);
        drive(0, 1, 1, 0, 4'd0);
        chk_out("up_start", 0, 0, 1);
        repeat (4 * (MAXV + 1) - 1) drive(0, 1, 1, 0, 4'd0);
        chk_out("up_before_wrap", MAXV, 0, 1);
        drive(0, 1, 1, 0, 4'd0);
        chk_out("up_wrap", 0, 1, 1);
        drive(0, 1, 1, 0, 4'd0);
        chk_out("up_wrap_tc_end", 0, 0, 1);

        // Load coinciding with a step at the top value
        drive(0, 1, 1, 1, 4'(MAXV));
        repeat (3) drive(0, 1, 1, 0, 4'd0);
        chk_out("pre_collide", MAXV, 0, 1);
        drive(0, 1, 1, 1, 4'd3);
        chk_out("load_vs_step", 3, 0, 1);

        // Reset beats a simultaneous load mid-run
        drive(0, 1, 1, 1, 4'd5);
        drive(0, 1, 1, 0, 4'd0);
        chk_out("pre_reset", 5, 0, 1);
        drive(1, 1, 1, 1, 4'd7);
        chk_out("reset_mid", 0, 0, 0);

        // Random stimulus against the model
        for (int i = 0; i < 2000; i++) begin
            bit r, rn, u, l;
            r  = ($urandom_range(99) == 0);
            rn = ($urandom_range(7) == 0) ? ~bus.run : bus.run;
            u  = ($urandom_range(3) == 0) ? ~bus.up_dn : bus.up_dn;
            l  = ($urandom_range(15) == 0);
            drive(r, rn, u, l, 4'($urandom_range(15)));
            chk("rnd_digit", 8'(bus.digit), 8'(m_digit));
            chk("rnd_tc",    8'(bus.tc),    8'(m_tc));
            chk("rnd_busy",  8'(bus.busy),  8'(m_run));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
